// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: producer/consumer handshake, data and status bundle for param_sync_fifo
interface param_sync_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;
   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with registered read port, count-derived flags and error pulses
module param_sync_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 4
) (
   input logic              clk,
   input logic              rst_n,
   param_sync_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              rd_acc, wr_acc;
   logic [CNT_W-1:0]  count_nxt;
   always_comb begin
      rd_acc    = bus.rd_en & ~bus.empty;
      wr_acc    = bus.wr_en & (~bus.full | rd_acc);
      count_nxt = (wr_acc & ~rd_acc) ? bus.count + CNT_W'(1) :
                  (rd_acc & ~wr_acc) ? bus.count - CNT_W'(1) : bus.count;
   end
   // storage is deliberately left out of reset so it maps onto plain SRAM
   always_ff @(posedge clk)
      if (wr_acc) mem[wr_ptr] <= bus.wr_data;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         bus.count        <= '0;
         bus.empty        <= 1'b1;
         bus.almost_empty <= 1'b1;
         bus.full         <= 1'b0;
         bus.almost_full  <= 1'b0;
         bus.rd_valid     <= 1'b0;
         bus.rd_data      <= '0;
         bus.overflow     <= 1'b0;
         bus.underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_acc) begin
            rd_ptr      <= rd_ptr + PTR_W'(1);
            bus.rd_data <= mem[rd_ptr];
         end
         bus.rd_valid     <= rd_acc;
         bus.overflow     <= bus.wr_en & ~wr_acc;
         bus.underflow    <= bus.rd_en & ~rd_acc;
         bus.count        <= count_nxt;
         bus.empty        <= count_nxt == '0;
         bus.full         <= count_nxt == CNT_W'(DEPTH);
         bus.almost_full  <= count_nxt >= CNT_W'(AFULL_TH);
         bus.almost_empty <= count_nxt <= CNT_W'(AEMPTY_TH);
      end
   end
endmodule
